// File: rtl/bcd_seg_scanner.sv
// Multiplexed 7-segment scanner for NUM_DIGITS packed BCD digits with load-strobe snapshot and sticky invalid-code flag.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading-zero digits (digit 0 always lit).
module bcd_seg_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   bcd_in,
    input  logic                      load,
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      invalid
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

    localparam logic [6:0] SEG_DASH = 7'b1000000;

    logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
    logic [PRE_W-1:0]        presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    invalid_q, invalid_d;

    logic                    tick;
    logic [3:0]              digit [NUM_DIGITS];
    logic [3:0]              sel_digit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit[gi] = snap_q[4*gi +: 4];
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    // zero_from[i]: digit i and every more-significant digit are zero.
    logic [NUM_DIGITS-1:0] zero_from;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_zero
            if (gi == NUM_DIGITS - 1) begin : g_top
                assign zero_from[gi] = (digit[gi] == 4'd0);
            end else begin : g_mid
                assign zero_from[gi] = (digit[gi] == 4'd0) && zero_from[gi+1];
            end
        end
    endgenerate
`endif

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    assign sel_digit = digit[idx_q];
    assign tick      = (presc_q == PRE_LAST);

    always_comb begin
        snap_d    = snap_q;
        presc_d   = presc_q;
        idx_d     = idx_q;
        an_d      = '0;
        seg_d     = decode(sel_digit);
        invalid_d = invalid_q;

        if (load) begin
            snap_d = bcd_in;
        end

        if (tick) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
            presc_d = presc_q + PRE_W'(1);
        end

        // Outputs follow the current (pre-edge) index and snapshot so an and seg stay paired.
        an_d[idx_q] = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        if (zero_from[idx_q] && (idx_q != '0)) begin
            seg_d = 7'b0000000;
        end
`endif
        if (sel_digit > 4'd9) begin
            invalid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            snap_q    <= '0;
            presc_q   <= '0;
            idx_q     <= '0;
            an_q      <= '0;
            seg_q     <= '0;
            invalid_q <= 1'b0;
        end else begin
            snap_q    <= snap_d;
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            invalid_q <= invalid_d;
        end
    end

    assign seg     = seg_q;
    assign an      = an_q;
    assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Directed bench for bcd_seg_scanner (NUM_DIGITS=4, SCAN_DIV=4) with a per-cycle scoreboard.
// Honours LEADING_ZERO_BLANK_EN the same way the design does.
module tb_bcd_seg_scanner;

    localparam int ND = 4;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [15:0]   bcd_in = '0;
    logic          load = 1'b0;
    logic [6:0]    seg;
    logic [3:0]    an;
    logic          invalid;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       inv;
    } exp_t;

    exp_t sb[$];

    logic [15:0] m_snap = '0;
    int          m_idx = 0;
    int          m_presc = 0;
    logic        m_inv = 1'b0;
    int          cyc = 0;

    bcd_seg_scanner #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
        .clk     (clk),
        .reset   (reset),
        .bcd_in  (bcd_in),
        .load    (load),
        .seg     (seg),
        .an      (an),
        .invalid (invalid)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0111111;
            4'd1: return 7'b0000110;
            4'd2: return 7'b1011011;
            4'd3: return 7'b1001111;
            4'd4: return 7'b1100110;
            4'd5: return 7'b1101101;
            4'd6: return 7'b1111101;
            4'd7: return 7'b0000111;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1101111;
            default: return 7'b1000000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: drive inputs, push the expected outputs of the coming edge, then pop and compare.
    task automatic step(input logic r, input logic ld, input logic [15:0] b);
        exp_t e;
        logic [3:0] d;
        logic blank;
        reset  = r;
        load   = ld;
        bcd_in = b;
        if (r) begin
            e = '0;
            m_snap = '0; m_idx = 0; m_presc = 0; m_inv = 1'b0;
        end else begin
            d = m_snap[m_idx*4 +: 4];
            e.an  = 4'(1 << m_idx);
            e.seg = dec(d);
            blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            if (m_idx > 0) begin
                blank = 1'b1;
                for (int j = m_idx; j < ND; j++)
                    if (m_snap[j*4 +: 4] != 4'd0) blank = 1'b0;
            end
`endif
            if (blank) e.seg = 7'b0000000;
            if (d > 4'd9) m_inv = 1'b1;
            e.inv = m_inv;
            if (ld) m_snap = b;
            if (m_presc == SD - 1) begin
                m_presc = 0;
                m_idx = (m_idx == ND - 1) ? 0 : m_idx + 1;
            end else begin
                m_presc = m_presc + 1;
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = sb.pop_front();
        chk("sb_an", 32'(an), 32'(e.an));
        chk("sb_seg", 32'(seg), 32'(e.seg));
        chk("sb_inv", 32'(invalid), 32'(e.inv));
        $display("cyc=%0d rst=%0b ld=%0b bcd=%h an=%b seg=%b inv=%0b", cyc, r, ld, b, an, seg, invalid);
    endtask

    // Step with inputs held until digit d is displayed, then check its segments.
    task automatic wait_digit(input int d, input logic [15:0] b, input logic [6:0] exp_seg, input string tag);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(1'b0, 1'b0, b);
            if (an === 4'(1 << d)) found = 1'b1;
        end
        chk({tag, "_found"}, 32'(found), 32'd1);
        if (found) chk(tag, 32'(seg), 32'(exp_seg));
    endtask

    initial begin
        int exp_idx;
        step(1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0);
        chk("rst_an", 32'(an), 32'h0);
        chk("rst_seg", 32'(seg), 32'h0);

        step(1'b0, 1'b0, 16'h0);
        chk("rel_an", 32'(an), 32'b0001);
        chk("rel_seg", 32'(seg), 32'b0111111);
        repeat (4) step(1'b0, 1'b0, 16'h0);
        chk("an_after4", 32'(an), 32'b0010);
        repeat (12) step(1'b0, 1'b0, 16'h0);
        chk("wrap_an", 32'(an), 32'b0001);

        step(1'b0, 1'b1, 16'h1209);
        wait_digit(0, 16'hFFFF, 7'b1101111, "d1209_0");
        wait_digit(1, 16'hFFFF, 7'b0111111, "d1209_1");
        wait_digit(2, 16'hFFFF, 7'b1011011, "d1209_2");
        wait_digit(3, 16'hFFFF, 7'b0000110, "d1209_3");
        chk("inv_clean", 32'(invalid), 32'd0);

        step(1'b0, 1'b1, 16'h00A3);
        wait_digit(1, 16'h0, 7'b1000000, "dash_1");
        chk("inv_rise", 32'(invalid), 32'd1);
        step(1'b0, 1'b1, 16'h0000);
        repeat (20) step(1'b0, 1'b0, 16'h0);
        chk("inv_sticky", 32'(invalid), 32'd1);

        for (int k = 0; k < 8 && m_presc != SD - 1; k++) step(1'b0, 1'b0, 16'h0);
        exp_idx = (m_idx + 1) % ND;
        step(1'b0, 1'b1, 16'h5555);
        step(1'b0, 1'b0, 16'h0);
        chk("ldtick_an", 32'(an), 32'(1 << exp_idx));
        chk("ldtick_seg", 32'(seg), 32'b1101101);

        step(1'b0, 1'b1, 16'h0040);
`ifdef LEADING_ZERO_BLANK_EN
        wait_digit(3, 16'h0, 7'b0000000, "b40_3");
        wait_digit(2, 16'h0, 7'b0000000, "b40_2");
`else
        wait_digit(3, 16'h0, 7'b0111111, "b40_3");
        wait_digit(2, 16'h0, 7'b0111111, "b40_2");
`endif
        wait_digit(1, 16'h0, 7'b1100110, "b40_1");
        wait_digit(0, 16'h0, 7'b0111111, "b40_0");
        step(1'b0, 1'b1, 16'h0000);
`ifdef LEADING_ZERO_BLANK_EN
        wait_digit(1, 16'h0, 7'b0000000, "b00_1");
        wait_digit(3, 16'h0, 7'b0000000, "b00_3");
`else
        wait_digit(1, 16'h0, 7'b0111111, "b00_1");
        wait_digit(3, 16'h0, 7'b0111111, "b00_3");
`endif
        wait_digit(0, 16'h0, 7'b0111111, "b00_0");

        for (int k = 0; k < 20 && m_idx != 2; k++) step(1'b0, 1'b0, 16'h0);
        chk("pre_rst_inv", 32'(invalid), 32'd1);
        step(1'b1, 1'b1, 16'h9999);
        chk("mid_rst_an", 32'(an), 32'h0);
        chk("mid_rst_seg", 32'(seg), 32'h0);
        chk("mid_rst_inv", 32'(invalid), 32'h0);
        step(1'b0, 1'b0, 16'h0);
        chk("post_rst_an", 32'(an), 32'b0001);
        chk("post_rst_seg", 32'(seg), 32'b0111111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_seg_scanner.md
Name: bcd_seg_scanner

Overview:
- Downstream consumer of the mod-10 counter stage: takes NUM_DIGITS packed BCD digits, one per cascaded counter, and drives a time-multiplexed common-bus 7-segment display.
- Snapshots the digit bus on a load strobe so the display never tears mid-count.
- Rotates one-hot digit enables at a programmable scan rate and decodes the selected digit to segments.
- Flags any non-BCD code seen on a displayed digit.

Parameters:
- NUM_DIGITS, 4, number of BCD digits and digit-enable lines (>=2).
- SCAN_DIV, 1000, clock cycles each digit stays selected (>=1).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- bcd_in  in  4*NUM_DIGITS  packed digits; bits [3:0] = digit 0 (least significant).
- load  in  1  capture bcd_in into snapshot register this cycle.
- seg  out  7  {g,f,e,d,c,b,a}; active-high segment drives; registered.
- an  out  NUM_DIGITS  one-hot active-high digit enable; bit i = digit i; registered.
- invalid  out  1  sticky flag; set when a code 10-15 is decoded; cleared only by reset.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset: snapshot=0, prescaler=0, digit index=0, an=0, seg=0, invalid=0.
- Snapshot: on load=1, snap <= bcd_in at the next edge. Display always reads snap, never bcd_in directly.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. tick = (prescaler == SCAN_DIV-1). SCAN_DIV=1 gives tick every cycle.
- Digit index: on tick, idx <= (idx == NUM_DIGITS-1) ? 0 : idx+1. Wraps modulo NUM_DIGITS.
- Output registers, updated every non-reset cycle:
  - an <= onehot(idx)
  - seg <= decode(snap[idx])
  - an and seg always change on the same edge, so they are never mismatched.
- Latency:
  - Index change at edge n produces matching an/seg at edge n+1.
  - load sampled at edge n updates snap at n; seg reflects the new data at edge n+1.
  - First cycle after reset deassert: an=0001, seg=decode(0).
- Decode table (seg[6:0]):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - 10-15 = 1000000 (dash), and invalid <= 1.
- invalid is set only when an invalid digit is actually selected for display, not on load.
- Simultaneous load and tick: both take effect. The new snapshot and the new index are used together for the next output.
- Reset mid-scan overrides load and tick; state returns to reset values on that edge.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: digit i (i>0) is blanked (seg=0000000) when snap[i] and all more-significant snapshot digits are 0. an is still asserted for a blanked digit. Digit 0 is never blanked. Invalid codes are never blanked.
- Undefined: all digits are decoded normally; zeros show 0111111.

Test Plan:
- NUM_DIGITS=4, SCAN_DIV=4; reset 2 cycles, release -> an=0001, seg=0111111; an=0010 after 4 cycles; sequence wraps back to 0001 after 16 cycles.
- load with bcd_in=16'h1209 -> in scan order the digits show seg=1101111, 0111111, 1011011, 0000110; snap holds after bcd_in changes with load=0.
- load with bcd_in=16'h00A3 -> digit 1 slot shows seg=1000000 and invalid rises the cycle that slot is output; invalid stays 1 after a reload of 16'h0000 until reset.
- load asserted on the same cycle as tick, with bcd_in=16'h5555 -> the next output shows the new index with seg=1101101.
- LEADING_ZERO_BLANK_EN defined, load 16'h0040 -> digits 3 and 2 are blank with an asserted, digit 1 shows 1100110, digit 0 shows 0111111; load 16'h0000 -> only digit 0 lit.
- reset asserted mid-scan (idx=2) -> next edge gives an=0, seg=0, invalid=0; the cycle after deassert gives an=0001.
